// File: rtl/rs_dispatch_arbiter_pkg.sv
// Shared dispatch-stage types: control word, buffered bundle, station ids, and
// the steering and CDB wakeup helpers used by the dispatch FIFO and arbiter.
package rs_dispatch_arbiter_pkg;

   localparam int REG_VAL_WIDTH          = 32;
   localparam int PHYSICAL_REG_NUM_WIDTH = 6;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       is_branch;
      logic [3:0] alu_op;
   } control_t;

   typedef struct packed {
      control_t                          control;
      logic [REG_VAL_WIDTH-1:0]          src1_val;
      logic [REG_VAL_WIDTH-1:0]          src2_val;
      logic [REG_VAL_WIDTH-1:0]          imm;
      logic [PHYSICAL_REG_NUM_WIDTH-1:0] src1_addr;
      logic [PHYSICAL_REG_NUM_WIDTH-1:0] src2_addr;
      logic [PHYSICAL_REG_NUM_WIDTH-1:0] dst_addr;
      logic                              src1_rdy;
      logic                              src2_rdy;
   } dispatch_bundle_t;

   typedef enum logic [0:0] {
      RS_ALU = 1'b0,
      RS_MEM = 1'b1
   } rs_id_t;

   function automatic rs_id_t dispatch_target(input control_t ctrl);
      rs_id_t tgt;
      tgt = (ctrl.mem_read || ctrl.mem_write) ? RS_MEM : RS_ALU;
      return tgt;
   endfunction

   // A waiting operand whose tag matches the broadcast takes the value and becomes ready.
   function automatic dispatch_bundle_t cdb_wakeup(
      input dispatch_bundle_t                  b,
      input logic                              en,
      input logic [PHYSICAL_REG_NUM_WIDTH-1:0] tag,
      input logic [REG_VAL_WIDTH-1:0]          val
   );
      dispatch_bundle_t r;
      r = b;
      if (en && !b.src1_rdy && (b.src1_addr == tag)) begin
         r.src1_val = val;
         r.src1_rdy = 1'b1;
      end
      if (en && !b.src2_rdy && (b.src2_addr == tag)) begin
         r.src2_val = val;
         r.src2_rdy = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rs_dispatch_arbiter_fifo.sv
// Power-of-two circular FIFO of dispatch bundles with flush and an in-place
// operand wakeup port applied to every stored entry each cycle.
module dispatch_fifo
   import rs_dispatch_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              push,
   input  dispatch_bundle_t                  push_data,
   input  logic                              pop,
   input  logic                              wake_en,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] wake_tag,
   input  logic [REG_VAL_WIDTH-1:0]          wake_val,
   output dispatch_bundle_t                  head,
   output logic [CNT_W-1:0]                  count,
   output logic                              full,
   output logic                              empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   dispatch_bundle_t mem_q [DEPTH];
   dispatch_bundle_t mem_d [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Stale slots are don't-care, so wakeup is applied to every slot without a valid mask.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = cdb_wakeup(mem_q[i], wake_en, wake_tag, wake_val);
      end
      if (push && !flush) begin
         mem_d[wr_ptr_q] = push_data;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/rs_dispatch_arbiter.sv
// In-order dispatch arbiter: buffers renamed bundles and steers the head to the
// ALU or MEM station when it has room. DISPATCH_CDB_BYPASS_EN enables CDB wakeup.
module rs_dispatch_arbiter
   import rs_dispatch_arbiter_pkg::*;
#(
   parameter int NUM_RS    = 2,
   parameter int BUF_DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  control_t                          in_control,
   input  logic [REG_VAL_WIDTH-1:0]          in_src1_val,
   input  logic [REG_VAL_WIDTH-1:0]          in_src2_val,
   input  logic [REG_VAL_WIDTH-1:0]          in_imm,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] in_src1_addr,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] in_src2_addr,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] in_dst_addr,
   input  logic                              in_src1_rdy,
   input  logic                              in_src2_rdy,
   input  logic [NUM_RS-1:0]                 rs_full,
   output logic [NUM_RS-1:0]                 out_valid,
   output control_t                          out_control,
   output logic [REG_VAL_WIDTH-1:0]          out_src1_val,
   output logic [REG_VAL_WIDTH-1:0]          out_src2_val,
   output logic [REG_VAL_WIDTH-1:0]          out_imm,
   output logic [PHYSICAL_REG_NUM_WIDTH-1:0] out_src1_addr,
   output logic [PHYSICAL_REG_NUM_WIDTH-1:0] out_src2_addr,
   output logic [PHYSICAL_REG_NUM_WIDTH-1:0] out_dst_addr,
   output logic                              out_src1_rdy,
   output logic                              out_src2_rdy,
   input  logic                              cdb_valid,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] cdb_tag,
   input  logic [REG_VAL_WIDTH-1:0]          cdb_val
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   logic             wake_en;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   rs_id_t           target;
   dispatch_bundle_t push_raw;
   dispatch_bundle_t push_bundle;
   dispatch_bundle_t fifo_head;
   dispatch_bundle_t head_byp;

`ifdef DISPATCH_CDB_BYPASS_EN
   assign wake_en = cdb_valid;
`else
   // Stations own all wakeup in this build; the CDB inputs are left unused.
   logic unused_cdb_valid;
   assign wake_en          = 1'b0;
   assign unused_cdb_valid = cdb_valid;
`endif

   always_comb begin
      push_raw           = '0;
      push_raw.control   = in_control;
      push_raw.src1_val  = in_src1_val;
      push_raw.src2_val  = in_src2_val;
      push_raw.imm       = in_imm;
      push_raw.src1_addr = in_src1_addr;
      push_raw.src2_addr = in_src2_addr;
      push_raw.dst_addr  = in_dst_addr;
      push_raw.src1_rdy  = in_src1_rdy;
      push_raw.src2_rdy  = in_src2_rdy;
      push_bundle        = cdb_wakeup(push_raw, wake_en, cdb_tag, cdb_val);
   end

   // in_ready comes from registered occupancy only, so a full FIFO never takes a same-cycle push.
   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready && !flush;

   assign target   = dispatch_target(fifo_head.control);
   assign pop      = !fifo_empty && !flush && !rs_full[target];
   assign head_byp = cdb_wakeup(fifo_head, wake_en, cdb_tag, cdb_val);

   always_comb begin
      out_valid = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         out_valid[i] = pop && (i == int'(target));
      end
   end

   assign out_control   = head_byp.control;
   assign out_src1_val  = head_byp.src1_val;
   assign out_src2_val  = head_byp.src2_val;
   assign out_imm       = head_byp.imm;
   assign out_src1_addr = head_byp.src1_addr;
   assign out_src2_addr = head_byp.src2_addr;
   assign out_dst_addr  = head_byp.dst_addr;
   assign out_src1_rdy  = head_byp.src1_rdy;
   assign out_src2_rdy  = head_byp.src2_rdy;

   dispatch_fifo #(
      .DEPTH (BUF_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_data (push_bundle),
      .pop       (pop),
      .wake_en   (wake_en),
      .wake_tag  (cdb_tag),
      .wake_val  (cdb_val),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (int'(fifo_count) <= BUF_DEPTH);
         assert (fifo_full == (int'(fifo_count) == BUF_DEPTH));
      end
   end

endmodule
